// File: rtl/voice_allocator.sv
// Voice slot table with note-on/off allocation, voice stealing and a round-robin slot readout.
// Latency: an event is written NBANKS+1 clk after acceptance; the readout lags the table by one clk_en edge.
// Backpressure: o_ready is low from acceptance until the table write; i_valid without o_ready is ignored.
module voice_allocator #(
    parameter int NBANKS = 10,
    parameter int SLOT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              i_valid,
    input  logic              i_note_on,
    input  logic [6:0]        i_note,
    output logic              o_ready,
    output logic [6:0]        o_midi,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_frame_start,
    output logic              o_steal
);
    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NBANKS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [6:0]        voice [NBANKS];
    logic [7:0]        age   [NBANKS];
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] idx;
    logic [SLOT_W-1:0] free_idx;
    logic [SLOT_W-1:0] old_idx;
    logic [SLOT_W-1:0] tgt;
    logic [7:0]        old_age;
    logic [6:0]        ev_note;
    logic              ev_on;
    logic              match_found;
    logic              free_found;
    logic              accept;
    logic              wr_en;

    assign o_ready = (state == IDLE) & ~rst;
    assign accept  = i_valid & o_ready;
    assign tgt     = free_found ? free_idx : old_idx;
    assign wr_en   = ev_on & (ev_note != 7'd0) & ~match_found;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SCAN;
            SCAN:    if (idx == LAST) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NBANKS; i++) begin
                voice[i] <= '0;
                age[i]   <= '0;
            end
            idx         <= '0;
            ev_on       <= 1'b0;
            ev_note     <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            old_idx     <= '0;
            old_age     <= '0;
            o_steal     <= 1'b0;
        end else begin
            o_steal <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ev_on       <= i_note_on;
                        ev_note     <= i_note;
                        idx         <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        free_idx    <= '0;
                        old_idx     <= '0;
                        old_age     <= '0;
                    end
                end
                SCAN: begin
                    if (!match_found && voice[idx] == ev_note) match_found <= 1'b1;
                    if (!free_found && voice[idx] == 7'd0) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
                    // Strict compare keeps the lowest index on equal ages.
                    if (age[idx] > old_age) begin
                        old_idx <= idx;
                        old_age <= age[idx];
                    end
                    idx <= idx + SLOT_W'(1);
                end
                COMMIT: begin
                    if (wr_en) begin
                        for (int i = 0; i < NBANKS; i++) begin
                            if (SLOT_W'(i) == tgt) begin
                                voice[i] <= ev_note;
                                age[i]   <= '0;
                            end else if (voice[i] != 7'd0 && age[i] != 8'hFF) begin
                                age[i] <= age[i] + 8'd1;
                            end
                        end
                        o_steal <= ~free_found;
                    end else if (!ev_on && ev_note != 7'd0) begin
                        // All duplicates of the note are released together.
                        for (int i = 0; i < NBANKS; i++) begin
                            if (voice[i] == ev_note) begin
                                voice[i] <= '0;
                                age[i]   <= '0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot          <= '0;
            o_midi        <= '0;
            o_slot        <= '0;
            o_frame_start <= 1'b0;
        end else if (clk_en) begin
            o_midi        <= voice[slot];
            o_slot        <= slot;
            o_frame_start <= (slot == '0);
            slot          <= (slot == LAST) ? '0 : slot + SLOT_W'(1);
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Randomized directed bench for voice_allocator against a rule-level table model.
module tb_voice_allocator;
    localparam int NB = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic       i_valid = 1'b0;
    logic       i_note_on = 1'b0;
    logic [6:0] i_note = '0;
    logic       o_ready;
    logic [6:0] o_midi;
    logic [3:0] o_slot;
    logic       o_frame_start;
    logic       o_steal;

    voice_allocator #(.NBANKS(NB), .SLOT_W(4)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .i_valid(i_valid),
        .i_note_on(i_note_on), .i_note(i_note), .o_ready(o_ready),
        .o_midi(o_midi), .o_slot(o_slot), .o_frame_start(o_frame_start),
        .o_steal(o_steal)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int m_voice [NB];
    int m_age   [NB];
    int busy = 0;
    int ev_on = 0;
    int ev_note = 0;
    int nxt_slot = 0;
    int exp_midi = 0;
    int exp_slot = 0;
    int exp_fs = 0;
    int exp_steal = 0;
    int en_mode = 1;
    int low_cnt = 0;
    int steal_cnt = 0;
    int seen [NB];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick_en();
        if (en_mode == 0) return 1'b0;
        if (en_mode == 1) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void apply_event(input int on, input int note);
        int held, tgt;
        exp_steal = 0;
        if (note == 0) return;
        if (on != 0) begin
            held = 0;
            foreach (m_voice[i]) if (m_voice[i] == note) held = 1;
            if (held != 0) return;
            tgt = -1;
            foreach (m_voice[i]) if (tgt < 0 && m_voice[i] == 0) tgt = i;
            if (tgt < 0) begin
                exp_steal = 1;
                tgt = 0;
                foreach (m_age[i]) if (m_age[i] > m_age[tgt]) tgt = i;
            end
            foreach (m_voice[i])
                if (i != tgt && m_voice[i] != 0) m_age[i] = (m_age[i] >= 255) ? 255 : m_age[i] + 1;
            m_voice[tgt] = note;
            m_age[tgt] = 0;
        end else begin
            foreach (m_voice[i]) if (m_voice[i] == note) begin
                m_voice[i] = 0;
                m_age[i] = 0;
            end
        end
    endfunction

    // One clock: drive, check o_ready before the edge, advance the model, check after the edge.
    task automatic tick(input logic en, input logic vld, input logic on, input logic [6:0] note, input logic r);
        clk_en = en; i_valid = vld; i_note_on = on; i_note = note; rst = r;
        #2;
        chk("o_ready", o_ready, (busy == 0 && !r) ? 1 : 0);
        if (o_ready !== 1'b1) low_cnt++;
        @(posedge clk);
        if (r) begin
            foreach (m_voice[i]) begin m_voice[i] = 0; m_age[i] = 0; end
            busy = 0; nxt_slot = 0; exp_midi = 0; exp_slot = 0; exp_fs = 0; exp_steal = 0;
        end else begin
            exp_steal = 0;
            if (en) begin
                exp_midi = m_voice[nxt_slot];
                exp_slot = nxt_slot;
                exp_fs = (nxt_slot == 0) ? 1 : 0;
                nxt_slot = (nxt_slot + 1) % NB;
            end
            if (busy > 0) begin
                busy--;
                if (busy == 0) apply_event(ev_on, ev_note);
            end else if (vld) begin
                ev_on = on; ev_note = note; busy = NB + 1;
            end
        end
        #1;
        chk("o_midi", o_midi, exp_midi);
        chk("o_slot", o_slot, exp_slot);
        chk("o_frame_start", o_frame_start, exp_fs);
        chk("o_steal", o_steal, exp_steal);
        if (o_steal === 1'b1) steal_cnt++;
    endtask

    task automatic send(input logic on, input logic [6:0] note);
        int n = 0;
        while (busy == 0 && n < 40) begin
            tick(pick_en(), 1'b1, on, note, 1'b0);
            n++;
        end
        low_cnt = 0;
        while (busy != 0)
            tick(pick_en(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 1'b0);
    endtask

    task automatic frame();
        for (int k = 0; k < NB; k++) begin
            tick(1'b1, 1'b0, 1'b0, 7'd0, 1'b0);
            if (o_slot < NB) seen[o_slot] = o_midi;
        end
    endtask

    task automatic do_reset();
        for (int k = 0; k < 3; k++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 7'd0, 1'b1);
    endtask

    int slot_before;
    int steals_before;

    initial begin
        #1;
        do_reset();
        // Idle sequencing right after reset.
        tick(1'b1, 1'b0, 1'b0, 7'd0, 1'b0);
        chk("first_slot", o_slot, 0);
        chk("first_fs", o_frame_start, 1);
        for (int k = 1; k < 25; k++) tick(1'b1, 1'b0, 1'b0, 7'd0, 1'b0);
        chk("slot_after_25", o_slot, 4);

        // Allocation order.
        en_mode = 1;
        send(1'b1, 7'h3C); chk("ready_low_clks", low_cnt, 11);
        send(1'b1, 7'h40); chk("ready_low_clks", low_cnt, 11);
        send(1'b1, 7'h43); chk("ready_low_clks", low_cnt, 11);
        frame();
        chk("alloc_s0", seen[0], 7'h3C);
        chk("alloc_s1", seen[1], 7'h40);
        chk("alloc_s2", seen[2], 7'h43);
        chk("alloc_s3", seen[3], 0);

        // Duplicates and note-off.
        send(1'b1, 7'h3C);
        send(1'b1, 7'h3C);
        frame();
        chk("dup_s3", seen[3], 0);
        send(1'b0, 7'h3C);
        frame();
        chk("off_s0", seen[0], 0);
        chk("off_s1", seen[1], 7'h40);
        send(1'b0, 7'h50);
        frame();
        chk("off_unheld_s2", seen[2], 7'h43);

        // Voice stealing.
        do_reset();
        en_mode = 2;
        for (int n = 0; n < NB; n++) send(1'b1, 7'(8'h30 + n));
        steals_before = steal_cnt;
        send(1'b1, 7'h45);
        tick(1'b1, 1'b0, 1'b0, 7'd0, 1'b0);
        chk("steal_pulses", steal_cnt - steals_before, 1);
        frame();
        chk("steal_s0", seen[0], 7'h45);
        chk("steal_s1_kept", seen[1], 7'h31);
        send(1'b1, 7'h46);
        frame();
        chk("steal2_s1", seen[1], 7'h46);
        chk("steal_total", steal_cnt - steals_before, 2);

        // Commit lands on the edge that reads its own slot.
        do_reset();
        en_mode = 1;
        while (nxt_slot != 9) tick(1'b1, 1'b0, 1'b0, 7'd0, 1'b0);
        send(1'b1, 7'h21);
        chk("coll_slot", o_slot, 0);
        chk("coll_old", o_midi, 0);
        frame();
        chk("coll_new", seen[0], 7'h21);

        // clk_en held low across a whole event.
        en_mode = 0;
        slot_before = o_slot;
        send(1'b1, 7'h22);
        for (int k = 0; k < 50 - (NB + 2); k++) tick(1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
        chk("gated_slot", o_slot, slot_before);
        frame();
        chk("gated_write", seen[1], 7'h22);

        // Reset four clocks after acceptance.
        steals_before = steal_cnt;
        tick(1'b1, 1'b1, 1'b1, 7'h55, 1'b0);
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b0, 7'd0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 7'd0, 1'b1);
        for (int k = 0; k < NB + 4; k++) tick(1'b1, 1'b0, 1'b0, 7'd0, 1'b0);
        chk("midscan_ready", o_ready, 1);
        frame();
        for (int k = 0; k < NB; k++) chk("midscan_clear", seen[k], 0);
        chk("midscan_nosteal", steal_cnt - steals_before, 0);

        // Random event mix on a small note pool.
        en_mode = 2;
        for (int n = 0; n < 40; n++) begin
            int nt;
            nt = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(8'h30, 8'h3D);
            send(1'($urandom_range(0, 3) != 0), 7'(nt));
            for (int k = $urandom_range(0, 3); k > 0; k--)
                tick(pick_en(), 1'b0, 1'b0, 7'd0, 1'b0);
        end
        frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/voice_allocator.md
# voice_allocator

Upstream feeder for the pipelined phase bank. Accepts MIDI note-on/note-off events over a valid/ready handshake and keeps a table of NBANKS voice slots. On every clock-enabled cycle it presents one slot's MIDI note, in round-robin order, as the phase bank's `i_midi` input. Note value 0 means "voice idle" throughout.

## Interface
- `NBANKS`, 10: number of voice slots. Must match the phase bank; range 2..16.
- `SLOT_W`, 4: slot index width; must satisfy 2^SLOT_W ≥ NBANKS.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous and active-high.
- `clk_en` in 1: sample-rate enable; advances the slot sequencer only.
- `i_valid` in 1: event present.
- `i_note_on` in 1: 1 = note-on, 0 = note-off.
- `i_note` in 7: MIDI note number.
- `o_ready` out 1: allocator can accept an event.
- `o_midi` out 7: note for the current slot, to the phase bank `i_midi` (0 = idle).
- `o_slot` out SLOT_W: slot index of `o_midi`.
- `o_frame_start` out 1: high when `o_slot` == 0.
- `o_steal` out 1: one-`clk` pulse when a note-on evicts an active voice.

## Operation
- **State.** Voice table `voice[i]` (7 bits each) and `age[i]` (8 bits each). All are cleared by reset.
- **Slot sequencer (only on `clk_en`).**
  - Registers `o_midi <= voice[slot]`, `o_slot <= slot`, `o_frame_start <= (slot==0)`.
  - `slot` then wraps NBANKS-1 → 0.
  - With `clk_en` low, the outputs and `slot` hold.
- **Event FSM (every `clk`, independent of `clk_en`).** States are IDLE, SCAN, COMMIT.
  - **IDLE:** `o_ready`=1. On `i_valid & o_ready`, latch note and on/off, set `idx`=0, go to SCAN.
  - **SCAN:** examines `voice[idx]` once per cycle, `idx` 0..NBANKS-1, and records:
    - the first index with `voice`==latched note (match);
    - the first index with `voice`==0 (free);
    - the index with the maximum `age` (oldest; lowest index wins ties).
    - At `idx`==NBANKS-1, go to COMMIT.
  - **COMMIT:** applies the event (rules below), then goes to IDLE.
- **Note-on rules.**
  - Note 0: no-op.
  - Match found: no-op (no retrigger).
  - Else a free slot exists: write the note there and set its `age`=0.
  - Else steal the oldest slot: write the note, set `age`=0, pulse `o_steal`.
  - On every write, every other non-idle voice gets `age+1`, saturating at 255.
- **Note-off rules.**
  - Every slot whose `voice` equals the note is cleared to 0, with `age` set to 0.
  - The scan records only the first match, but COMMIT clears all equal slots in parallel.
  - Note-off for a note not held, or for note 0: no-op.
- **COMMIT vs. sequencer collision.** If COMMIT writes the slot being read on the same edge, `o_midi` takes the old value; the new value appears on that slot's next visit.
- **Reset mid-scan.** The event is discarded, the FSM returns to IDLE, and no table write occurs.

## Timing
- **Reset values:**
  - `o_midi`=0, `o_slot`=0, `o_frame_start`=0, `o_steal`=0;
  - `slot`=0, FSM=IDLE;
  - all `voice` and `age` entries 0.
- **`o_ready`.** Combinational: (state==IDLE) & ~`rst`.
- **Event timeline, accepted at edge k:**
  - SCAN covers edges k+1..k+NBANKS;
  - the table is written at edge k+NBANKS+1;
  - `o_ready` is high again after edge k+NBANKS+1, so the minimum event spacing is NBANKS+2 clocks.
- **`o_steal`.** Registered; high for exactly the cycle after the stealing COMMIT edge.
- **Sequencer latency.** First `clk_en` edge after reset gives `o_slot`=0, `o_frame_start`=1. Output lags `voice[slot]` by one `clk_en` edge.
- **`i_valid` without `o_ready`.** Ignored; the source must hold the event until accepted.

## Test plan
- **Reset and idle sequencing.** Reset, then 25 consecutive `clk_en` edges, no events → `o_slot` 0,1..9,0..9,0..4; `o_midi`=0 throughout; `o_frame_start` high exactly when `o_slot`=0.
- **Allocation order.** Note-on 0x3C, 0x40, 0x43 → slots 0,1,2 hold them; each event holds `o_ready` low for 11 clocks; the following frame shows `o_midi` 0x3C,0x40,0x43,0,… at slots 0..2.
- **Duplicate and note-off.** Note-on 0x3C twice, then note-off 0x3C → only slot 0 was used; slot 0 reads 0 on the next visit. Note-off 0x50 (not held) leaves the table unchanged.
- **Voice stealing.** Note-on 0x30..0x39 fills all 10 slots. Note-on 0x45 → `o_steal` pulses once, slot 0 (oldest, note 0x30) becomes 0x45. Next note-on 0x46 steals slot 1.
- **Collision and gating.** Time COMMIT to coincide with the `clk_en` edge reading the target slot → old value output, new value on the next frame. Hold `clk_en` low for 50 clocks while an event completes → sequencer outputs frozen, table updated.
- **Reset mid-scan.** Assert `rst` 4 clocks after accepting a note-on → after reset the table is all 0, `o_ready`=1, no `o_steal`.
